// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16-channel mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational priority search: lowest enabled channel strictly above cur,
// or the lowest enabled channel overall when search_all is set.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              search_all,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Ascending scan; the first hit wins, so the result is the lowest qualifying index.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (search_all || (i > 32'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_16to1_scan_ctrl.sv
// Channel-scan engine for a 16-to-1 bit mux: walks the select across the
// enabled channels, samples Y after SETTLE cycles each and hands the
// assembled snapshot out on a valid/ready handshake.
module mux_16to1_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              y_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [NUM_CH-1:0] snap_data,
  output logic [CNT_W-1:0]  snap_count
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  scan_state_t       state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [3:0]        settle_q, settle_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_CH-1:0] srch_mask;
  logic [SEL_W-1:0]  srch_cur;
  logic              srch_all;
  logic [SEL_W-1:0]  srch_nxt;
  logic              srch_found;

  // In IDLE the search looks at the incoming mask for the first channel;
  // while scanning it looks above the current select in the latched mask.
  always_comb begin
    srch_mask = mask_q;
    srch_cur  = sel_q;
    srch_all  = 1'b0;
    if (state_q == StIdle) begin
      srch_mask = chan_mask;
      srch_cur  = '0;
      srch_all  = 1'b1;
    end
  end

  mux_scan_next_ch u_next_ch (
    .mask       (srch_mask),
    .cur        (srch_cur),
    .search_all (srch_all),
    .nxt        (srch_nxt),
    .found      (srch_found)
  );

  // Next-state logic for the FSM, settle counter and snapshot.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    data_d   = data_q;
    count_d  = count_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mask_d   = chan_mask;
          data_d   = '0;
          count_d  = '0;
          settle_d = '0;
          if (srch_found) begin
            sel_d   = srch_nxt;
            state_d = StScan;
          end else begin
            state_d = StDone;
          end
        end
      end
      StScan: begin
        if (settle_q < SettleLast) begin
          settle_d = settle_q + 4'd1;
        end else begin
          // Last edge of this channel's settle window: capture Y and move on.
          data_d[sel_q] = y_in;
          count_d       = count_q + 5'd1;
          settle_d      = '0;
          if (srch_found) begin
            sel_d = srch_nxt;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (snap_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      sel_q    <= '0;
      settle_q <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = (state_q != StIdle);
  assign snap_valid = (state_q == StDone);
  assign snap_data  = data_q;
  assign snap_count = count_q;

endmodule

// File: tb/tb_mux_16to1_scan_ctrl.sv
// Scoreboard bench: two scan engines (SETTLE=1 and SETTLE=3) share stimulus;
// expected snapshots are queued at start and checked by per-lane monitors.
module tb_mux_16to1_scan_ctrl;
  import mux_scan_pkg::*;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] data;
    logic [4:0]  count;
    int unsigned e0;
    int unsigned lat;
    logic [3:0]  sel_final;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] chan_mask;
  logic [15:0] mux_in;
  logic [1:0]  y_in;
  logic [1:0]  busy;
  logic [1:0]  snap_valid;
  logic [1:0]  snap_ready;
  logic [3:0]  sel        [2];
  logic [15:0] snap_data  [2];
  logic [4:0]  snap_count [2];

  exp_t        exp_q [2][$];
  logic [3:0]  last_sel [2];
  int unsigned cyc;
  int          total;
  int          bad;
  int          ready_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL lane%0d %s act=%0h exp=%0h t=%0t", g, name, act, req, $time);
    end
  endtask

  // Ready driver: 0 random, 1 held low, 2 held high; changes just after posedge.
  initial begin
    snap_ready = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 2; g++) begin
        if (ready_mode == 2) snap_ready[g] = 1'b1;
        else if (ready_mode == 1) snap_ready[g] = 1'b0;
        else snap_ready[g] = 1'($urandom_range(0, 1));
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned S = (g == 0) ? 1 : 3;

    // Behavioural 16-to-1 mux.
    assign y_in[g] = mux_in[sel[g]];

    mux_16to1_scan_ctrl #(
      .SETTLE (S)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .chan_mask  (chan_mask),
      .y_in       (y_in[g]),
      .sel        (sel[g]),
      .busy       (busy[g]),
      .snap_valid (snap_valid[g]),
      .snap_ready (snap_ready[g]),
      .snap_data  (snap_data[g]),
      .snap_count (snap_count[g])
    );

    exp_t       cur;
    logic [3:0] tr[$];

    // Monitor: records the select trace, checks each snapshot as valid rises,
    // its stability while valid, and the state after the handshake.
    initial begin
      logic prev_v;
      logic hs;
      int   k;
      prev_v = 1'b0;
      hs     = 1'b0;
      forever begin
        @(negedge clk);
        if (!busy[g]) tr.delete();
        else if (!snap_valid[g]) tr.push_back(sel[g]);
        if (hs) begin
          hs = 1'b0;
          check("hs_valid", g, 32'(snap_valid[g]), 32'd0);
          check("hs_busy", g, 32'(busy[g]), 32'd0);
          check("hs_data", g, 32'(snap_data[g]), 32'(cur.data));
          check("hs_count", g, 32'(snap_count[g]), 32'(cur.count));
        end else if (snap_valid[g] && !prev_v) begin
          if (exp_q[g].size() == 0) begin
            check("valid_unexpected", g, 32'(snap_valid[g]), 32'd0);
          end else begin
            cur = exp_q[g].pop_front();
            check("data", g, 32'(snap_data[g]), 32'(cur.data));
            check("count", g, 32'(snap_count[g]), 32'(cur.count));
            check("latency", g, cyc - cur.e0, cur.lat);
            check("sel_final", g, 32'(sel[g]), 32'(cur.sel_final));
            check("busy_done", g, 32'(busy[g]), 32'd1);
            k = 0;
            for (int ch = 0; ch < 16; ch++) begin
              if (cur.mask[ch]) begin
                for (int r = 0; r < int'(S); r++) begin
                  if (k < tr.size()) check("sel_trace", g, 32'(tr[k]), 32'(ch));
                  k++;
                end
              end
            end
            check("trace_len", g, tr.size(), k);
          end
        end else if (snap_valid[g] && prev_v) begin
          check("hold_data", g, 32'(snap_data[g]), 32'(cur.data));
          check("hold_count", g, 32'(snap_count[g]), 32'(cur.count));
        end
        if (snap_valid[g] && snap_ready[g]) hs = 1'b1;
        prev_v = snap_valid[g];
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != 2'b00) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("timeout_idle", 0, 32'(busy), 32'd0);
  endtask

  task automatic check_zero();
    for (int g = 0; g < 2; g++) begin
      check("rst_sel", g, 32'(sel[g]), 32'd0);
      check("rst_busy", g, 32'(busy[g]), 32'd0);
      check("rst_valid", g, 32'(snap_valid[g]), 32'd0);
      check("rst_data", g, 32'(snap_data[g]), 32'd0);
      check("rst_count", g, 32'(snap_count[g]), 32'd0);
    end
  endtask

  // Issue a scan once both lanes are idle; queue the expected snapshot.
  task automatic do_scan(input logic [15:0] m);
    exp_t e;
    wait_idle();
    chan_mask = m;
    start     = 1'b1;
    for (int g = 0; g < 2; g++) begin
      e.mask  = m;
      e.data  = m & mux_in;
      e.count = 5'($countones(m));
      e.e0    = cyc + 1;
      e.lat   = int'($countones(m)) * ((g == 0) ? 1 : 3);
      for (int ch = 0; ch < 16; ch++) if (m[ch]) last_sel[g] = 4'(ch);
      e.sel_final = last_sel[g];
      exp_q[g].push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    chan_mask = 16'($urandom);
  endtask

  initial begin
    int          n;
    logic [15:0] m;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    chan_mask  = '0;
    mux_in     = '0;
    ready_mode = 2;
    last_sel[0] = '0;
    last_sel[1] = '0;
    repeat (3) @(negedge clk);
    check_zero();
    rst_n = 1'b1;

    mux_in = 16'hA5C3;
    do_scan(16'hFFFF);
    wait_idle();
    mux_in = 16'hFFFF;
    do_scan(16'h8101);
    wait_idle();
    do_scan(16'h0000);
    wait_idle();

    // Backpressure: hold ready low in DONE and pulse start with other masks.
    ready_mode = 1;
    mux_in = 16'h3C5A;
    do_scan(16'h0F0F);
    n = 0;
    while ((snap_valid != 2'b11) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("timeout_valid", 0, 32'(snap_valid), 32'd3);
    for (int i = 0; i < 10; i++) begin
      start     = 1'(i % 2);
      chan_mask = 16'($urandom);
      mux_in    = 16'($urandom);
      @(negedge clk);
    end
    start      = 1'b0;
    ready_mode = 2;
    wait_idle();
    mux_in = 16'h1E2D;
    do_scan(16'h00F0);
    wait_idle();

    // Reset mid-scan at sel=5 on the fast lane; the partial snapshot is dropped.
    ready_mode = 0;
    do_scan(16'hFFFF);
    n = 0;
    while ((sel[0] != 4'd5) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout_sel5", 0, 32'(sel[0]), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero();
    for (int g = 0; g < 2; g++) begin
      exp_q[g].delete();
      last_sel[g] = '0;
    end
    do_scan(16'h0030);
    wait_idle();

    // Toggle In[3] after channel 3 has been sampled on both lanes.
    mux_in = 16'($urandom);
    do_scan(16'h00FF);
    repeat (12) @(negedge clk);
    mux_in[3] = ~mux_in[3];
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      wait_idle();
      mux_in = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       m = 16'h0000;
        1:       m = 16'hFFFF;
        2:       m = 16'(1 << $urandom_range(0, 15));
        default: m = 16'($urandom & $urandom);
      endcase
      do_scan(m);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) check("queue_drained", g, exp_q[g].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_16to1_scan_ctrl.md
# mux_16to1_scan_ctrl

Sequencer that sits directly upstream and downstream of the 16-to-1 bit multiplexer. It drives the mux's 4-bit select, walks it across a caller-supplied set of enabled channels, and samples the mux output Y once per channel after a programmable settle time. It then presents the assembled 16-bit snapshot on a valid/ready handshake. The block converts the combinational mux into a per-request channel-scan engine.

## Interface
- `SETTLE`, default 1: cycles each channel's select is held before Y is sampled; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  scan request; honoured only in IDLE.
- `chan_mask`  in  16  enabled channels; bit i enables channel i; latched on the accepted `start`.
- `y_in`  in  1  mux output Y; combinational from `sel`.
- `sel`  out  4  select driven to the mux.
- `busy`  out  1  high in SCAN and DONE.
- `snap_valid`  out  1  snapshot available.
- `snap_ready`  in  1  consumer accepts the snapshot.
- `snap_data`  out  16  bit i = sampled Y of channel i; 0 for masked channels.
- `snap_count`  out  5  number of channels sampled (0..16).

## Operation
- States are IDLE, SCAN and DONE.
- On reset, all outputs are 0 and the state is IDLE.
- **IDLE:**
  - On the edge with `start`=1, latch `chan_mask`.
  - Clear `snap_data`, `snap_count` and the settle counter.
  - If the mask is non-zero, load `sel` with the lowest set bit and go to SCAN.
  - If the mask is zero, go straight to DONE with `snap_count`=0 and `snap_data`=0.
- **SCAN:**
  - Each edge, if the settle counter is below SETTLE-1, increment it.
  - Otherwise:
    - Write `y_in` into `snap_data[sel]` and increment `snap_count`.
    - Clear the settle counter.
    - Load `sel` with the next set mask bit above `sel`. If there is none, go to DONE.
  - Masked channels are skipped at zero cycle cost.
- **DONE:**
  - `snap_valid`=1.
  - `snap_data` and `snap_count` are held stable.
  - On the edge with `snap_ready`=1, go to IDLE.
- `snap_valid` drops after the handshake edge; `snap_data` and `snap_count` keep their values until the next accepted `start`.
- `start` is ignored outside IDLE, including in the handshake cycle. The earliest new scan starts one cycle after DONE exits.
- `sel` holds its last value outside SCAN. Reset returns it to 0.
- `snap_ready` is ignored outside DONE.
- A `rst_n`=0 at any edge, including mid-scan or during DONE, forces IDLE with all outputs 0 on that edge. A partial snapshot is discarded.
- Channel index arithmetic is 4-bit with no wrap. The scan ends after the highest set bit and never revisits channel 0.

## Timing
- Let E0 be the edge that accepts `start`.
- With N enabled channels, `snap_valid` rises on edge E0 + N·SETTLE.
- Mask 0: `snap_valid` rises on E0 + 0, i.e. it is visible in the cycle after E0.
- Full mask, SETTLE=1: `sel` runs 0..15 in the cycles after E0..E15 and `snap_valid` rises on E16.
- `y_in` is sampled on the last edge of each channel's SETTLE window. The mux path from `sel` to `y_in` must meet one cycle.
- `busy` is registered and aligned with the state: it rises on E0 and falls on the handshake edge.

## Structure
- Package `mux_scan_pkg` holds:
  - state enum `scan_state_t` (IDLE, SCAN, DONE);
  - constants `NUM_CH`=16, `SEL_W`=4, `CNT_W`=5.
- Sub-module `mux_scan_next_ch`: combinational priority search. Inputs are the mask and the current index; outputs are the next set index strictly above the current one and a `found` flag. It is also used with a "start from −1" mode to find the first channel.
- Top level holds the FSM, settle counter and snapshot registers, and instantiates `mux_16to1` only in the bench.

## Test plan
- Full mask 0xFFFF, SETTLE=1, mux inputs 0xA5C3, `snap_ready`=1 → `snap_valid` on E16, `snap_data`=0xA5C3, `snap_count`=16, `sel` sequence 0..15.
- Mask 0x8101, SETTLE=3, inputs 0xFFFF → `sel` visits 0, 8, 15 for 3 cycles each, `snap_valid` on E9, `snap_data`=0x8101, `snap_count`=3.
- Mask 0x0000 → `snap_valid` on E0, `snap_data`=0, `snap_count`=0, `sel` unchanged.
- Hold `snap_ready`=0 for 10 cycles in DONE while pulsing `start` with a new mask → snapshot and mask unchanged; after the ready edge, IDLE; `start` the next cycle is accepted.
- `rst_n`=0 for one edge during SCAN at `sel`=5 → next cycle is IDLE with `sel`=0, `busy`=0, `snap_valid`=0, `snap_data`=0, `snap_count`=0; a following scan of mask 0x0030 gives `snap_count`=2.
- Inputs change mid-scan (In[3] toggles after channel 3 is sampled) → `snap_data[3]` keeps the value sampled on its SETTLE edge.
